// File: rtl/sram_sim_pkg.sv
// Shared defaults and helpers for the behavioural SRAM model.
// The top and the array both import this package.
package sram_sim_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_WMASK_WIDTH = 4;

  // Width of one write-mask lane; the data width must divide evenly.
  function automatic int lane_w(input int data_w, input int mask_w);
    return data_w / mask_w;
  endfunction

endpackage

// File: rtl/sram_sim_array.sv
// Raw RAM_DEPTH x DATA_WIDTH storage with a masked synchronous write and a registered read.
// The contents are never reset, so they survive a reset pulse.
module sram_sim_array
  import sram_sim_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WMASK_WIDTH = DEF_WMASK_WIDTH,
  parameter int RAM_DEPTH   = 1 << DEF_ADDR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   in_range,
  output logic [DATA_WIDTH-1:0]  dout
);

  localparam int LW = lane_w(DATA_WIDTH, WMASK_WIDTH);

  logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1];

  always_ff @(posedge clock) begin
    if (we && in_range) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (wmask[i]) mem[addr][i*LW +: LW] <= din[i*LW +: LW];
      end
    end
  end

  // Out-of-range reads return zero; writes leave dout untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout <= '0;
    end else if (!we) begin
      dout <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/sram_sim_top.sv
// Single-port synchronous SRAM model with an input-register stage in front of the array.
// Read data appears two rising edges after the request is presented.
module sram_sim_top
  import sram_sim_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WMASK_WIDTH = DEF_WMASK_WIDTH,
  parameter int RAM_DEPTH   = 1 << ADDR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout
);

  logic                   we_reg;
  logic [WMASK_WIDTH-1:0] wmask_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [DATA_WIDTH-1:0]  din_reg;
  logic                   in_range;

  // Stage 1: capture the request; reset drops whatever was held here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_reg    <= 1'b0;
      wmask_reg <= '0;
      addr_reg  <= '0;
      din_reg   <= '0;
    end else begin
      we_reg    <= we;
      wmask_reg <= wmask;
      addr_reg  <= addr;
      din_reg   <= din;
    end
  end

  assign in_range = 32'(addr_reg) < RAM_DEPTH;

  // Stage 2: array access with the registered request.
  sram_sim_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WMASK_WIDTH (WMASK_WIDTH),
    .RAM_DEPTH   (RAM_DEPTH)
  ) u_array (
    .clock    (clock),
    .reset_n  (reset_n),
    .we       (we_reg),
    .wmask    (wmask_reg),
    .addr     (addr_reg),
    .din      (din_reg),
    .in_range (in_range),
    .dout     (dout)
  );

endmodule

// File: tb/tb_sram_sim_top.sv
// Directed bench for sram_sim_top: reads are scored through a queue of expected
// results, each due two edges after the request is driven.
module tb_sram_sim_top;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int MW    = 4;
  localparam int DEPTH = 200;

  logic          clock;
  logic          reset_n;
  logic          we;
  logic [MW-1:0] wmask;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  sram_sim_top #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .WMASK_WIDTH (MW),
    .RAM_DEPTH   (DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we),
    .wmask   (wmask),
    .addr    (addr),
    .din     (din),
    .dout    (dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [DW-1:0] exp;
    bit          neq;
    string       tag;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [0:255];
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic push_exp(input int due, input logic [DW-1:0] exp, input bit neq, input string tag);
    exp_t e;
    e.due = due; e.exp = exp; e.neq = neq; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_due();
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.due != cyc) begin
        errors++;
        $error("FAIL %s: result slot missed at cycle %0d, due %0d", e.tag, cyc, e.due);
      end else if (e.neq) begin
        assert (dout !== e.exp) else begin
          errors++;
          $error("FAIL %s: dout=%h must differ from %h", e.tag, dout, e.exp);
        end
      end else begin
        assert (dout === e.exp) else begin
          errors++;
          $error("FAIL %s: dout=%h expected %h", e.tag, dout, e.exp);
        end
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clock);
    cyc++;
    #1;
    check_due();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    @(negedge clock);
    we = 1'b1; wmask = m; addr = a; din = d;
    if (int'(a) < DEPTH) begin
      for (int i = 0; i < MW; i++) if (m[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
    end
    edge_step();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input bit neq, input string tag);
    @(negedge clock);
    we = 1'b0; wmask = '0; addr = a; din = '0;
    push_exp(cyc + 2, exp, neq, tag);
    edge_step();
  endtask

  // A write with no lanes enabled changes nothing and keeps dout steady.
  task automatic idle();
    do_write(8'd0, '0, '0);
  endtask

  task automatic check_now(input logic [DW-1:0] exp, input string tag);
    checks++;
    assert (dout === exp) else begin
      errors++;
      $error("FAIL %s: dout=%h expected %h", tag, dout, exp);
    end
  endtask

  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1 check_now('0, "rst_dout_clear");
    sb.delete();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] ra;
    reset_n = 1'b0;
    we = 1'b1; wmask = '0; addr = '0; din = '0;
    repeat (2) @(posedge clock);
    #1 check_now('0, "reset_state");
    @(negedge clock);
    reset_n = 1'b1;
    edge_step();

    do_write(8'd0, 32'hA5A5_A5A5, 4'hF);

    // Test 1: simple write then read.
    do_write(8'd5, 32'd42, 4'hF);
    do_read(8'd5, 32'd42, 1'b0, "t1_read5");
    idle();

    // Test 2: masked overwrite.
    do_write(8'd3, 32'hFFFF_FFFF, 4'hF);
    do_write(8'd3, 32'h1234_5678, 4'b0101);
    do_read(8'd3, 32'hFF34_FF78, 1'b0, "t2_mask");
    idle();

    // Test 3: fully pipelined back-to-back traffic.
    do_write(8'd1, 32'd7, 4'hF);
    do_write(8'd2, 32'd9, 4'hF);
    do_read(8'd1, 32'd7, 1'b0, "t3_read1");
    do_read(8'd2, 32'd9, 1'b0, "t3_read2");
    idle();
    idle();

    // Test 4: read right after write; dout held across later writes.
    do_write(8'd10, 32'd99, 4'hF);
    do_read(8'd10, 32'd99, 1'b0, "t4_read10");
    idle();
    idle();
    check_now(32'd99, "t4_hold_idle");
    do_write(8'd11, 32'd5, 4'hF);
    idle();
    check_now(32'd99, "t4_hold_write");

    // Range boundary: last word works, out-of-range write ignored, read is zero.
    do_write(8'd199, 32'hCAFE_0199, 4'hF);
    do_write(8'd250, 32'hDEAD_BEEF, 4'hF);
    do_read(8'd199, 32'hCAFE_0199, 1'b0, "last_word");
    do_read(8'd250, 32'h0, 1'b0, "oor_read");
    idle();

    // Test 5: reset mid-cycle clears dout, array retained.
    do_write(8'd4, 32'd55, 4'hF);
    do_read(8'd4, 32'd55, 1'b0, "t5_pre_rst");
    idle();
    reset_pulse();
    push_exp(cyc + 1, 32'hA5A5_A5A5, 1'b0, "t5_first_read_addr0");
    do_read(8'd4, 32'd55, 1'b0, "t5_retained");
    idle();

    // Test 6: write held in stage 1 at reset is dropped.
    do_write(8'd6, 32'd1, 4'hF);
    reset_pulse();
    push_exp(cyc + 1, 32'hA5A5_A5A5, 1'b0, "t6_first_read_addr0");
    do_read(8'd6, 32'd1, 1'b1, "t6_write_dropped");
    idle();

    // Randomised masked traffic against the reference model.
    for (int a = 20; a < 28; a++) do_write(AW'(a), $urandom, 4'hF);
    for (int k = 0; k < 12; k++) begin
      ra = AW'($urandom_range(20, 27));
      do_write(ra, $urandom, MW'($urandom_range(0, 15)));
    end
    for (int a = 20; a < 28; a++) do_read(AW'(a), model[a], 1'b0, $sformatf("rand_read%0d", a));

    for (int k = 0; k < 4 && sb.size() > 0; k++) idle();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $error("FAIL drain: %0d results still pending, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
